// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles the sequencer's program-ROM fetch bus, ALU control/flag signals
//   and its start/busy/done status into one interface.
//
//   Signals:
//     start        begin execution at address 0 (sampled only while idle)
//     ins_addr     ROM address (ROM answers on ins_data one cycle later)
//     ins_data     16-bit instruction word: [15:11] opcode, [PC_W-1:0] target
//     alu_control  5-bit ALU control code, 0 when not issuing
//     alu_z        ALU zero flag, delayed by the ALU pipeline depth
//     result_we    one-cycle writeback strobe in the ALU issue cycle
//     busy         high whenever the sequencer is not idle
//     done         one-cycle pulse when a HALT retires
//     step         (only with SEQ_STEP_EN) single-step permission for fetch
//
//   Modports:
//     master  the sequencer itself
//     slave   the environment (ROM, ALU, controller)
//
//   Optional feature macro: SEQ_STEP_EN adds the step signal.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic [PC_W-1:0] ins_addr;
    logic [15:0]     ins_data;
    logic [4:0]      alu_control;
    logic            alu_z;
    logic            result_we;
    logic            busy;
    logic            done;
`ifdef SEQ_STEP_EN
    logic            step;
`endif

    modport master (
`ifdef SEQ_STEP_EN
        input  step,
`endif
        input  start,
        input  ins_data,
        input  alu_z,
        output ins_addr,
        output alu_control,
        output result_we,
        output busy,
        output done
    );

    modport slave (
`ifdef SEQ_STEP_EN
        output step,
`endif
        output start,
        output ins_data,
        output alu_z,
        input  ins_addr,
        input  alu_control,
        input  result_we,
        input  busy,
        input  done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Issuing end of the ALU control interface. Fetches 16-bit instructions
//   from a synchronous ROM, issues ALU ops for exactly one cycle with a
//   writeback strobe, and resolves branch-on-zero against the ALU zero flag
//   that comes back Z_LAT cycles after the issue cycle.
//
//   Parameters:
//     PC_W   program counter / ROM address width (must match the interface)
//     Z_LAT  cycles from the issue cycle to the matching alu_z
//
//   Ports:
//     clk    system clock, everything on posedge
//     rst    synchronous active-high reset
//     bus    alu_op_sequencer_if.master (ROM bus, ALU control, status)
//
//   Opcodes ([15:11]): 00001..01011 and 11100 are ALU ops, 11111 BZ,
//   11110 JMP, 11101 HALT, everything else is a NOP.
//
//   Optional feature macro: SEQ_STEP_EN -- FETCH waits for bus.step=1,
//   giving one instruction per step pulse. Without it FETCH always advances.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int PC_W  = 8,
    parameter int Z_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    alu_op_sequencer_if.master bus
);
    localparam int AGE_W = $clog2(Z_LAT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(Z_LAT);
    localparam logic [AGE_W-1:0] AGE_ARM = AGE_W'(Z_LAT - 1);

    localparam logic [4:0] OP_BZ   = 5'b11111;
    localparam logic [4:0] OP_JMP  = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ZWAIT,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] ins_addr_reg;
    logic [PC_W-1:0] target_reg;
    logic [4:0]      alu_control_reg;
    logic            result_we_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [AGE_W-1:0] age_reg;
    logic            zflag_reg;
    logic            zvalid_reg;

    logic [4:0]      opcode;
    logic [PC_W-1:0] ins_target;
    logic [PC_W-1:0] pc_inc;
    logic            fetch_go;

    function automatic logic is_alu_op(input logic [4:0] op);
        return ((op >= 5'b00001) && (op <= 5'b01011)) || (op == 5'b11100);
    endfunction

    assign opcode     = bus.ins_data[15:11];
    assign ins_target = bus.ins_data[PC_W-1:0];
    // Natural PC_W-bit overflow gives the required wrap to 0.
    assign pc_inc     = pc_reg + PC_W'(1);

`ifdef SEQ_STEP_EN
    assign fetch_go = bus.step;
`else
    assign fetch_go = 1'b1;
`endif

    // Instruction bits between the target field and the opcode carry no
    // meaning for narrow program counters.
    generate
        if (PC_W < 11) begin : g_unused_bits
            logic unused_ins_bits;
            assign unused_ins_bits = ^bus.ins_data[10:PC_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            ins_addr_reg    <= '0;
            target_reg      <= '0;
            alu_control_reg <= '0;
            result_we_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            age_reg         <= AGE_MAX;
            zflag_reg       <= 1'b0;
            zvalid_reg      <= 1'b1;
        end else begin
            // Pulsed outputs default low; the issue/halt paths raise them.
            alu_control_reg <= '0;
            result_we_reg   <= 1'b0;
            done_reg        <= 1'b0;

            // Zero-flag tracking: age counts edges since the last issue and
            // the flag of that op is captured when it reaches the ALU output.
            if (age_reg != AGE_MAX) begin
                age_reg <= age_reg + AGE_W'(1);
                if (age_reg == AGE_ARM) begin
                    zflag_reg  <= bus.alu_z;
                    zvalid_reg <= 1'b1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_reg       <= '0;
                        ins_addr_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_FETCH;
                    end
                end

                // ins_addr is loaded together with pc on every transition
                // into FETCH, so the ROM already sees it during this cycle
                // and ins_data is valid in DECODE.
                S_FETCH: begin
                    ins_addr_reg <= pc_reg;
                    if (fetch_go) begin
                        state_reg <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    target_reg <= ins_target;
                    if (is_alu_op(opcode)) begin
                        alu_control_reg <= opcode;
                        result_we_reg   <= 1'b1;
                        state_reg       <= S_EXEC;
                    end else if (opcode == OP_BZ) begin
                        state_reg <= S_ZWAIT;
                    end else if (opcode == OP_JMP) begin
                        pc_reg       <= ins_target;
                        ins_addr_reg <= ins_target;
                        state_reg    <= S_FETCH;
                    end else if (opcode == OP_HALT) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        pc_reg       <= pc_inc;
                        ins_addr_reg <= pc_inc;
                        state_reg    <= S_FETCH;
                    end
                end

                // Issue cycle: re-arm tracking so the last issue always wins
                // (overrides any capture of an older op on this same edge).
                S_EXEC: begin
                    age_reg      <= '0;
                    zvalid_reg   <= 1'b0;
                    pc_reg       <= pc_inc;
                    ins_addr_reg <= pc_inc;
                    state_reg    <= S_FETCH;
                end

                S_ZWAIT: begin
                    if (zvalid_reg) begin
                        pc_reg       <= zflag_reg ? target_reg : pc_inc;
                        ins_addr_reg <= zflag_reg ? target_reg : pc_inc;
                        state_reg    <= S_FETCH;
                    end
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ins_addr    = ins_addr_reg;
    assign bus.alu_control = alu_control_reg;
    assign bus.result_we   = result_we_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;

endmodule
